// File: rtl/memshare_alloc_sched.sv
// rtl/memshare_alloc_sched.sv - allocation-sequence scheduler in front of the memShare datapath
//
// Buffers request patterns in a TRACK_DEPTH-deep tracking FIFO, applies the three memShare DRCs
// to each popped pattern and splits it into at most two allocation sequences (SEQ0/SEQ1), which
// are issued over a valid/ready handshake.
//
// Optional feature macro: MEMSHARE_SCHED_STAT_EN (adds saturating statistic counters).
//
// Ports:
//   sys_clk        clock, rising edge
//   rstn           asynchronous active-low reset
//   rqst_valid     arriving pattern valid
//   rqst_pattern   requester bitmask [RQST_NUM]
//   rqst_ready     tracking FIFO not full
//   alloc_valid    allocation sequence valid
//   alloc_ready    datapath accepts the sequence
//   alloc_mask     requesters in this sequence [RQST_NUM]
//   alloc_seq_id   0 = SEQ0, 1 = SEQ1
//   alloc_last     last sequence of the pattern
//   drc_err        sticky DRC flags, bit i = DRC index i [3]
//   drc_err_clr    synchronous clear of drc_err (and statistics when enabled)
//   busy           FIFO non-empty or FSM not idle
//   stat_pat_cnt   accepted patterns              (MEMSHARE_SCHED_STAT_EN only)
//   stat_split_cnt two-sequence patterns          (MEMSHARE_SCHED_STAT_EN only)
//   stat_rej_cnt   DRC-rejected patterns          (MEMSHARE_SCHED_STAT_EN only)

module memshare_alloc_sched #(
    parameter int RQST_NUM    = 8,
    parameter int SHARE_CAP   = 4,
    parameter int TRACK_DEPTH = 4,
    parameter int SEQ_GAP     = 1,
    parameter int STAT_W      = 16
) (
    input  logic                sys_clk,
    input  logic                rstn,
    input  logic                rqst_valid,
    input  logic [RQST_NUM-1:0] rqst_pattern,
    output logic                rqst_ready,
    output logic                alloc_valid,
    input  logic                alloc_ready,
    output logic [RQST_NUM-1:0] alloc_mask,
    output logic                alloc_seq_id,
    output logic                alloc_last,
    output logic [2:0]          drc_err,
    input  logic                drc_err_clr,
    output logic                busy
`ifdef MEMSHARE_SCHED_STAT_EN
    ,
    output logic [STAT_W-1:0]   stat_pat_cnt,
    output logic [STAT_W-1:0]   stat_split_cnt,
    output logic [STAT_W-1:0]   stat_rej_cnt
`endif
);

    localparam int AW = $clog2(TRACK_DEPTH);
    localparam int CW = $clog2(RQST_NUM + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEQ0 = 2'd1,
        ST_GAP  = 2'd2,
        ST_SEQ1 = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Tracking FIFO
    logic [RQST_NUM-1:0] fifo_mem [TRACK_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         fifo_cnt;
    logic                push, pop;
    logic [RQST_NUM-1:0] head;

    // DRC and split of the FIFO head, evaluated in the pop cycle
    logic [CW-1:0]       head_n;
    logic [CW-1:0]       taken;
    logic [RQST_NUM-1:0] head_seq0, head_seq1;
    logic                head_split;
    logic                drc1, drc2, drc3;
    logic                accept, reject;

    // Registered sequence masks of the pattern in flight
    logic [RQST_NUM-1:0] seq0_mask, seq1_mask;
    logic                split_r;

    logic [2:0]          gap_cnt;
    logic                gap_done;
    logic [2:0]          idle_seen;
    logic                hs;

    assign rqst_ready = (fifo_cnt != (AW+1)'(TRACK_DEPTH));
    assign push       = rqst_valid & rqst_ready;
    assign pop        = (state == ST_IDLE) && (fifo_cnt != '0);
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rqst_pattern;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // SEQ0 takes the lowest SHARE_CAP set bits, scanning from the LSB; SEQ1 gets the rest.
    always_comb begin
        head_n    = '0;
        taken     = '0;
        head_seq0 = '0;
        for (int i = 0; i < RQST_NUM; i++) begin
            head_n = head_n + CW'(head[i]);
            if (head[i] && (taken < CW'(SHARE_CAP))) begin
                head_seq0[i] = 1'b1;
                taken        = taken + CW'(1);
            end
        end
    end

    assign head_seq1  = head & ~head_seq0;
    assign head_split = head_n > CW'(SHARE_CAP);
    assign drc1       = head_n > CW'(2 * SHARE_CAP);
    assign drc2       = (head == '0);
    assign reject     = pop & (drc1 | drc2);
    assign accept     = pop & ~(drc1 | drc2);

    assign hs       = alloc_valid & alloc_ready;
    assign gap_done = (32'(gap_cnt) + 32'd1) >= 32'(SEQ_GAP);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            seq0_mask <= '0;
            seq1_mask <= '0;
            split_r   <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                seq0_mask <= head_seq0;
                seq1_mask <= head_seq1;
                split_r   <= head_split;
            end
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_SEQ0;
            ST_SEQ0: begin
                if (alloc_ready) begin
                    if (!split_r)          state_nxt = ST_IDLE;
                    else if (SEQ_GAP == 0) state_nxt = ST_SEQ1;
                    else                   state_nxt = ST_GAP;
                end
            end
            ST_GAP:  if (gap_done) state_nxt = ST_SEQ1;
            ST_SEQ1: if (alloc_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Independent watchdog for DRC3: counts idle output cycles since the SEQ0 handshake and
    // flags a SEQ1 handshake that comes too early. It never fires while the FSM is correct.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            idle_seen <= '0;
        end else if (hs && (state == ST_SEQ0)) begin
            idle_seen <= '0;
        end else if (!alloc_valid && (idle_seen != 3'd7)) begin
            idle_seen <= idle_seen + 3'd1;
        end
    end

    assign drc3 = hs && (state == ST_SEQ1) && (32'(idle_seen) < 32'(SEQ_GAP));

    // A new error in the clear cycle wins over the clear.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            drc_err <= '0;
        end else begin
            drc_err <= (drc_err_clr ? 3'b000 : drc_err) | {drc3, pop & drc2, pop & drc1};
        end
    end

    assign alloc_valid  = (state == ST_SEQ0) || (state == ST_SEQ1);
    assign alloc_seq_id = (state == ST_SEQ1);
    assign alloc_last   = (state == ST_SEQ1) || ((state == ST_SEQ0) && !split_r);
    assign alloc_mask   = (state == ST_SEQ1) ? seq1_mask :
                          (state == ST_SEQ0) ? seq0_mask : '0;
    assign busy         = (fifo_cnt != '0) || (state != ST_IDLE);

`ifdef MEMSHARE_SCHED_STAT_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            stat_pat_cnt   <= '0;
            stat_split_cnt <= '0;
            stat_rej_cnt   <= '0;
        end else if (drc_err_clr) begin
            stat_pat_cnt   <= '0;
            stat_split_cnt <= '0;
            stat_rej_cnt   <= '0;
        end else begin
            if (accept && (stat_pat_cnt != STAT_MAX))
                stat_pat_cnt <= stat_pat_cnt + STAT_W'(1);
            if (accept && head_split && (stat_split_cnt != STAT_MAX))
                stat_split_cnt <= stat_split_cnt + STAT_W'(1);
            if (reject && (stat_rej_cnt != STAT_MAX))
                stat_rej_cnt <= stat_rej_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_memshare_alloc_sched.sv
// tb/tb_memshare_alloc_sched.sv - self-checking bench for memshare_alloc_sched

module tb_memshare_alloc_sched;

    localparam int SHARE_CAP = 4;
    localparam int SEQ_GAP   = 1;

    logic        sys_clk = 1'b0;
    logic        rstn    = 1'b0;

    logic        rqst_valid = 1'b0;
    logic [7:0]  rqst_pattern = '0;
    logic        rqst_ready;
    logic        alloc_valid;
    logic        alloc_ready = 1'b0;
    logic [7:0]  alloc_mask;
    logic        alloc_seq_id;
    logic        alloc_last;
    logic [2:0]  drc_err;
    logic        drc_err_clr = 1'b0;
    logic        busy;

    logic        rqst_valid16 = 1'b0;
    logic [15:0] rqst_pattern16 = '0;
    logic        rqst_ready16;
    logic        alloc_valid16;
    logic        alloc_ready16 = 1'b1;
    logic [15:0] alloc_mask16;
    logic        alloc_seq_id16;
    logic        alloc_last16;
    logic [2:0]  drc_err16;
    logic        busy16;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0] exp_q [$];

    always #5 sys_clk = ~sys_clk;

    memshare_alloc_sched #(.RQST_NUM(8), .SHARE_CAP(SHARE_CAP), .TRACK_DEPTH(4), .SEQ_GAP(SEQ_GAP)) u_dut (
        .sys_clk(sys_clk), .rstn(rstn),
        .rqst_valid(rqst_valid), .rqst_pattern(rqst_pattern), .rqst_ready(rqst_ready),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_mask(alloc_mask),
        .alloc_seq_id(alloc_seq_id), .alloc_last(alloc_last),
        .drc_err(drc_err), .drc_err_clr(drc_err_clr), .busy(busy)
    );

    memshare_alloc_sched #(.RQST_NUM(16), .SHARE_CAP(SHARE_CAP), .TRACK_DEPTH(4), .SEQ_GAP(SEQ_GAP)) u_dut16 (
        .sys_clk(sys_clk), .rstn(rstn),
        .rqst_valid(rqst_valid16), .rqst_pattern(rqst_pattern16), .rqst_ready(rqst_ready16),
        .alloc_valid(alloc_valid16), .alloc_ready(alloc_ready16), .alloc_mask(alloc_mask16),
        .alloc_seq_id(alloc_seq_id16), .alloc_last(alloc_last16),
        .drc_err(drc_err16), .drc_err_clr(1'b0), .busy(busy16)
    );

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // Expected beats {mask, seq_id, last} of one pattern, derived from popcount and LSB-first peel-off.
    function automatic void add_pattern(input logic [7:0] p);
        logic [7:0] rem, lsb, s0;
        int n;
        n = $countones(p);
        if (n == 0 || n > 2 * SHARE_CAP) return;
        if (n <= SHARE_CAP) begin
            exp_q.push_back({p, 1'b0, 1'b1});
            return;
        end
        rem = p;
        s0  = '0;
        for (int k = 0; k < SHARE_CAP; k++) begin
            lsb = rem & (~rem + 8'd1);
            s0  = s0 | lsb;
            rem = rem & ~lsb;
        end
        exp_q.push_back({s0, 1'b0, 1'b0});
        exp_q.push_back({rem, 1'b1, 1'b1});
    endfunction

    task automatic test_reset;
        rstn = 1'b0;
        rqst_valid = 1'b0; alloc_ready = 1'b0; drc_err_clr = 1'b0;
        tick;
        tests_run++;
        if ({rqst_ready, alloc_valid, alloc_mask, alloc_seq_id, alloc_last, drc_err, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs got rdy=%0b v=%0b m=%h id=%0b l=%0b e=%b b=%0b exp rdy=1 rest 0",
                     rqst_ready, alloc_valid, alloc_mask, alloc_seq_id, alloc_last, drc_err, busy);
        end
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_single;
        rqst_valid = 1'b1; rqst_pattern = 8'h05; alloc_ready = 1'b1;
        tick;
        rqst_valid = 1'b0;
        tests_run++;
        if (alloc_valid !== 1'b0) begin
            tests_failed++; $display("FAIL single_pop_cycle valid got %0b exp 0", alloc_valid);
        end
        tick;
        tests_run++;
        if ({alloc_valid, alloc_mask, alloc_seq_id, alloc_last} !== {1'b1, 8'h05, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL single_beat got v=%0b m=%h id=%0b l=%0b exp v=1 m=05 id=0 l=1", alloc_valid, alloc_mask, alloc_seq_id, alloc_last);
        end
        tick;
        tests_run++;
        if ({alloc_valid, busy} !== 2'b00) begin
            tests_failed++; $display("FAIL single_done got v=%0b busy=%0b exp 0 0", alloc_valid, busy);
        end
    endtask

    task automatic test_split;
        rqst_valid = 1'b1; rqst_pattern = 8'hFF; alloc_ready = 1'b1;
        tick;
        rqst_valid = 1'b0;
        tick;
        tests_run++;
        if ({alloc_valid, alloc_mask, alloc_seq_id, alloc_last} !== {1'b1, 8'h0F, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL split_seq0 got v=%0b m=%h id=%0b l=%0b exp v=1 m=0f id=0 l=0", alloc_valid, alloc_mask, alloc_seq_id, alloc_last);
        end
        tick;
        tests_run++;
        if (alloc_valid !== 1'b0) begin
            tests_failed++; $display("FAIL split_gap valid got %0b exp 0", alloc_valid);
        end
        tick;
        tests_run++;
        if ({alloc_valid, alloc_mask, alloc_seq_id, alloc_last} !== {1'b1, 8'hF0, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL split_seq1 got v=%0b m=%h id=%0b l=%0b exp v=1 m=f0 id=1 l=1", alloc_valid, alloc_mask, alloc_seq_id, alloc_last);
        end
        tick;
        tests_run++;
        if ({alloc_valid, busy} !== 2'b00) begin
            tests_failed++; $display("FAIL split_done got v=%0b busy=%0b exp 0 0", alloc_valid, busy);
        end
    endtask

    task automatic test_drc_zero;
        alloc_ready = 1'b1;
        rqst_valid = 1'b1; rqst_pattern = 8'h00;
        tick;
        rqst_pattern = 8'h03;
        tick;
        rqst_valid = 1'b0;
        tests_run++;
        if ({drc_err, alloc_valid} !== {3'b010, 1'b0}) begin
            tests_failed++; $display("FAIL drc2_flag got err=%b v=%0b exp err=010 v=0", drc_err, alloc_valid);
        end
        tick;
        tests_run++;
        if ({alloc_valid, alloc_mask, alloc_seq_id, alloc_last} !== {1'b1, 8'h03, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL drc2_next_beat got v=%0b m=%h id=%0b l=%0b exp v=1 m=03 id=0 l=1", alloc_valid, alloc_mask, alloc_seq_id, alloc_last);
        end
        tick;
        drc_err_clr = 1'b1;
        tick;
        drc_err_clr = 1'b0;
        tests_run++;
        if (drc_err !== 3'b000) begin
            tests_failed++; $display("FAIL drc_clear got %b exp 000", drc_err);
        end
    endtask

    task automatic test_drc_overcap;
        logic saw_valid;
        rqst_valid16 = 1'b1; rqst_pattern16 = 16'h01FF;
        tick;
        rqst_valid16 = 1'b0;
        tick;
        tests_run++;
        if (drc_err16 !== 3'b001) begin
            tests_failed++; $display("FAIL drc1_flag got %b exp 001", drc_err16);
        end
        saw_valid = alloc_valid16;
        for (int k = 0; k < 4; k++) begin
            tick;
            saw_valid = saw_valid | alloc_valid16;
        end
        tests_run++;
        if ({saw_valid, busy16} !== 2'b00) begin
            tests_failed++; $display("FAIL drc1_no_beat got valid_seen=%0b busy=%0b exp 0 0", saw_valid, busy16);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_m [6];
        exp_m = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00};
        alloc_ready = 1'b0;
        rqst_valid = 1'b1;
        rqst_pattern = 8'h01; tick;
        rqst_pattern = 8'h02; tick;
        rqst_pattern = 8'h04; tick;
        rqst_valid = 1'b0;
        alloc_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if ({alloc_valid, alloc_mask} !== {(exp_m[k] != 8'h00), exp_m[k]}) begin
                tests_failed++;
                $display("FAIL b2b_cycle%0d got v=%0b m=%h exp v=%0b m=%h", k, alloc_valid, alloc_mask, exp_m[k] != 8'h00, exp_m[k]);
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] pats [5];
        logic [9:0] beat;
        int cyc;
        exp_q.delete();
        alloc_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pats[k] = 8'($urandom_range(1, 255));
            add_pattern(pats[k]);
        end
        rqst_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rqst_pattern = pats[k];
            tests_run++;
            if (rqst_ready !== 1'b1) begin
                tests_failed++; $display("FAIL bp_ready_push%0d got %0b exp 1", k, rqst_ready);
            end
            tick;
        end
        rqst_valid = 1'b0;
        tests_run++;
        if (rqst_ready !== 1'b0) begin
            tests_failed++; $display("FAIL bp_full got rqst_ready=%0b exp 0", rqst_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({alloc_valid, alloc_mask, alloc_seq_id, alloc_last} !== {1'b1, exp_q[0]}) begin
                tests_failed++;
                $display("FAIL bp_stall%0d got v=%0b beat=%h exp v=1 beat=%h", k, alloc_valid, {alloc_mask, alloc_seq_id, alloc_last}, exp_q[0]);
            end
            tick;
        end
        alloc_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 100) begin
            if (alloc_valid) begin
                beat = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
                tests_run++;
                if ({alloc_mask, alloc_seq_id, alloc_last} !== beat) begin
                    tests_failed++;
                    $display("FAIL bp_order got m=%h id=%0b l=%0b exp beat=%h", alloc_mask, alloc_seq_id, alloc_last, beat);
                end
            end
            tick;
            cyc++;
        end
        tests_run++;
        if ({exp_q.size() == 0, busy, rqst_ready} !== 3'b101) begin
            tests_failed++;
            $display("FAIL bp_drain left=%0d busy=%0b rqst_ready=%0b exp 0 0 1", exp_q.size(), busy, rqst_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic saw_valid;
        alloc_ready = 1'b1;
        rqst_valid = 1'b1; rqst_pattern = 8'hFF;
        tick;
        rqst_valid = 1'b0;
        tick;
        tick;
        tests_run++;
        if ({alloc_valid, busy} !== 2'b01) begin
            tests_failed++; $display("FAIL rstmid_in_gap got v=%0b busy=%0b exp 0 1", alloc_valid, busy);
        end
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if ({alloc_valid, busy, rqst_ready} !== 3'b001) begin
            tests_failed++; $display("FAIL rstmid_async got v=%0b busy=%0b rdy=%0b exp 0 0 1", alloc_valid, busy, rqst_ready);
        end
        tick;
        rstn = 1'b1;
        tick;
        rqst_valid = 1'b1; rqst_pattern = 8'h01;
        tick;
        rqst_valid = 1'b0;
        tick;
        tests_run++;
        if ({alloc_valid, alloc_mask, alloc_seq_id, alloc_last} !== {1'b1, 8'h01, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL rstmid_beat got v=%0b m=%h id=%0b l=%0b exp v=1 m=01 id=0 l=1", alloc_valid, alloc_mask, alloc_seq_id, alloc_last);
        end
        saw_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            saw_valid = saw_valid | alloc_valid;
        end
        tests_run++;
        if ({saw_valid, busy} !== 2'b00) begin
            tests_failed++; $display("FAIL rstmid_residue got valid_seen=%0b busy=%0b exp 0 0", saw_valid, busy);
        end
    endtask

    task automatic test_random;
        logic [9:0] beat, prev_beat;
        logic       prev_stall, saw_zero, gap_watch, done;
        int         idle_cnt, cyc;
        exp_q.delete();
        drc_err_clr = 1'b1; tick; drc_err_clr = 1'b0;
        prev_stall = 1'b0; saw_zero = 1'b0; gap_watch = 1'b0; idle_cnt = 0; done = 1'b0;
        prev_beat = '0;
        cyc = 0;
        while (!done && cyc < 800) begin
            if (prev_stall) begin
                tests_run++;
                if ({alloc_valid, alloc_mask, alloc_seq_id, alloc_last} !== {1'b1, prev_beat}) begin
                    tests_failed++;
                    $display("FAIL rnd_stable cyc%0d got v=%0b beat=%h exp v=1 beat=%h", cyc, alloc_valid, {alloc_mask, alloc_seq_id, alloc_last}, prev_beat);
                end
            end
            if (gap_watch) begin
                if (!alloc_valid) begin
                    idle_cnt++;
                end else begin
                    gap_watch = 1'b0;
                    tests_run++;
                    if (idle_cnt != SEQ_GAP) begin
                        tests_failed++; $display("FAIL rnd_gap cyc%0d got %0d idle cycles exp %0d", cyc, idle_cnt, SEQ_GAP);
                    end
                end
            end
            if (cyc < 400) begin
                alloc_ready  = ($urandom_range(0, 9) < 7);
                rqst_valid   = $urandom_range(0, 1) == 1;
                rqst_pattern = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
                if (rqst_valid && rqst_ready) begin
                    add_pattern(rqst_pattern);
                    if (rqst_pattern == 8'h00) saw_zero = 1'b1;
                end
            end else begin
                rqst_valid  = 1'b0;
                alloc_ready = 1'b1;
                done = (exp_q.size() == 0) && !busy;
            end
            if (alloc_valid && alloc_ready) begin
                beat = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
                tests_run++;
                if ({alloc_mask, alloc_seq_id, alloc_last} !== beat) begin
                    tests_failed++;
                    $display("FAIL rnd_beat cyc%0d got m=%h id=%0b l=%0b exp beat=%h", cyc, alloc_mask, alloc_seq_id, alloc_last, beat);
                end
                if (!alloc_last) begin
                    gap_watch = 1'b1;
                    idle_cnt  = 0;
                end
            end
            prev_stall = alloc_valid && !alloc_ready;
            prev_beat  = {alloc_mask, alloc_seq_id, alloc_last};
            if (!done) tick;
            cyc++;
        end
        tests_run++;
        if (!done) begin
            tests_failed++; $display("FAIL rnd_timeout left=%0d busy=%0b exp drained", exp_q.size(), busy);
        end
        tests_run++;
        if (drc_err !== {1'b0, saw_zero, 1'b0}) begin
            tests_failed++; $display("FAIL rnd_drc got %b exp %b", drc_err, {1'b0, saw_zero, 1'b0});
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_split;
        test_drc_zero;
        test_drc_overcap;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
